// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with wait states.
// It accepts one RV32I load/store, steers it to the byte lanes of a word
// array, and returns load data (sign/zero extended) or an error flag.
//
// Both handshakes use the same rule. A transfer happens on a rising edge
// where valid and ready are both high. The source keeps valid and its
// payload stable until that edge.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // The counter is loaded with WAIT_CYCLES+1 so that the response always
  // arrives WAIT_CYCLES+1 edges after the accept edge (one cycle even with 0).
  localparam int CW = $clog2(WAIT_CYCLES + 2);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH+1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [2:0]            f3_q, f3_d;
  logic                  err_q, err_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic [31:0] mem [DEPTH];

  logic        req_err;
  logic        commit;
  logic        wr_en;
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ld_ext;
  logic [3:0]  wr_be;
  logic [31:0] wr_lanes;

  // Fault detection on the incoming request: misalignment, range, funct3.
  always_comb begin
    req_err = 1'b0;
    if (req_funct3[1:0] == 2'b01 && req_addr[0]) req_err = 1'b1;
    if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) req_err = 1'b1;
    if (req_addr[31:ADDR_WIDTH+2] != '0) req_err = 1'b1;
    if (req_we) begin
      if (req_funct3 > 3'd2) req_err = 1'b1;
    end else begin
      if (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111)
        req_err = 1'b1;
    end
  end

  assign commit  = (state_q == ST_WAIT) && (cnt_q == CNT_ONE);
  assign wr_en   = commit && we_q && !err_q;
  assign rd_word = mem[addr_q[ADDR_WIDTH+1:2]];

  // Load lane selection and sign/zero extension from the latched request.
  always_comb begin
    rd_byte = rd_word[8*addr_q[1:0] +: 8];
    rd_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
    case (f3_q)
      3'b000:  ld_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  ld_ext = {24'd0, rd_byte};
      3'b001:  ld_ext = {{16{rd_half[15]}}, rd_half};
      3'b101:  ld_ext = {16'd0, rd_half};
      3'b010:  ld_ext = rd_word;
      default: ld_ext = 32'd0;
    endcase
  end

  // Store byte enables and right-aligned data replicated onto every lane.
  always_comb begin
    case (f3_q[1:0])
      2'b00:   begin wr_be = 4'b0001 << addr_q[1:0];                wr_lanes = {4{wdata_q[7:0]}};  end
      2'b01:   begin wr_be = addr_q[1] ? 4'b1100 : 4'b0011;         wr_lanes = {2{wdata_q[15:0]}}; end
      default: begin wr_be = 4'b1111;                               wr_lanes = wdata_q;            end
    endcase
  end

  // Storage write at the commit edge; the array itself has no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[addr_q[ADDR_WIDTH+1:2]][8*i +: 8] <= wr_lanes[8*i +: 8];
      end
    end
  end

  // Next-state, request latching and response capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    f3_d      = f3_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    rsp_err_d = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr[ADDR_WIDTH+1:0];
          wdata_d = req_wdata;
          f3_d    = req_funct3;
          err_d   = req_err;
          cnt_d   = CNT_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d   = ST_RESP;
          rsp_err_d = err_q;
          rdata_d   = (we_q || err_q) ? 32'd0 : ld_ext;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d   = ST_IDLE;
          rdata_d   = 32'd0;
          rsp_err_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any uncommitted transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 32'd0;
      f3_q      <= 3'd0;
      err_q     <= 1'b0;
      rdata_q   <= 32'd0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      f3_q      <= f3_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = rsp_err_q;
  assign dbg_state_o = state_q;

endmodule
